countdown_timer_controller: RTL

COUNTDOWN_TIMER_CONTROLLER -- requirements
Module: countdown_timer_controller

---
 rtl/countdown_timer_controller.sv | 124 ++++++++++++
 1 files changed

// File: rtl/countdown_timer_controller.sv
// Countdown timer: prescaled down-counter with IDLE/RUN/PAUSE/EXPIRED control and a registered done pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload from the preset after the terminal tick instead of expiring.
module countdown_timer_controller #(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expired,
  output logic             done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PAUSE   = 2'd2;
  localparam logic [1:0] EXPIRED = 2'd3;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [1:0]       state, state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload, reload_d;
  logic [PW-1:0]    presc, presc_d;
  logic             done_d;
  logic             tick;

  assign tick    = (presc == TICK_LAST);
  assign running = (state == RUN);
  assign expired = (state == EXPIRED);

  always_comb begin
    state_d  = state;
    count_d  = count;
    reload_d = reload;
    presc_d  = presc;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        presc_d = '0;
        if (clear) begin
          count_d = '0;
        end else if (load) begin
          count_d  = load_value;
          reload_d = load_value;
        end else if (start && (count != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (clear) begin
          state_d = IDLE;
          count_d = '0;
          presc_d = '0;
        end else if (stop) begin
          // prescaler phase is held so a resume continues mid-period
          state_d = PAUSE;
        end else begin
          presc_d = tick ? '0 : presc + 1'b1;
          if (tick) begin
            if (count > WIDTH'(1)) begin
              count_d = count - 1'b1;
            end else if (count == WIDTH'(1)) begin
              count_d = '0;
              done_d  = 1'b1;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
              state_d = EXPIRED;
`endif
            end
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            else begin
              count_d = reload;
            end
`endif
          end
        end
      end
      PAUSE: begin
        if (clear) begin
          state_d = IDLE;
          count_d = '0;
          presc_d = '0;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: begin
        presc_d = '0;
        if (clear) begin
          state_d = IDLE;
          count_d = '0;
        end else if (load) begin
          state_d  = IDLE;
          count_d  = load_value;
          reload_d = load_value;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      presc  <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      count  <= count_d;
      reload <= reload_d;
      presc  <= presc_d;
      done   <= done_d;
    end
  end

endmodule
